// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
// Instruction prefetch queue feeding the fetch/decode pipeline register.
// Owns the fetch PC, issues addresses to instruction memory and buffers the
// returned words, tagged with their PC, in a small circular FIFO. Decode
// drains one entry per cycle unless stalled. A redirect flushes the queue and
// restarts fetch at the new target.
//
// Ports:
//   clk          - single clock, all state updates on the rising edge
//   reset        - synchronous active-high reset
//   imem_addr    - fetch address to instruction memory (the fetch PC register)
//   imem_data    - instruction word for imem_addr, valid when imem_valid = 1
//   imem_valid   - memory returned imem_data this cycle
//   stall        - decode cannot accept, blocks dequeue
//   redirect     - taken branch/jump this cycle, flushes the queue
//   redirect_pc  - new fetch target, low two bits forced to zero
//   out_valid    - out_* holds a valid instruction
//   out_instr    - instruction at the queue head
//   out_pc       - address of out_instr
//   out_pc4      - out_pc + 4
//   count        - current occupancy, 0..DEPTH
//
// Optional feature: define IFQ_BYPASS_EN to forward imem_data straight to
// out_* when the queue is empty.
// ----------------------------------------------------------------------------
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic [31:0]                  imem_addr,
   input  logic [31:0]                  imem_data,
   input  logic                         imem_valid,
   input  logic                         stall,
   input  logic                         redirect,
   input  logic [31:0]                  redirect_pc,
   output logic                         out_valid,
   output logic [31:0]                  out_instr,
   output logic [31:0]                  out_pc,
   output logic [31:0]                  out_pc4,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [31:0]   pcMem    [DEPTH];
   logic [31:0]   instrMem [DEPTH];

   logic [31:0]   fetchPc_q, fetchPc_d;
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [CW-1:0] count_q, count_d;

   logic          queueValid;
   logic          pop;
   logic          push;
   logic          advance;
   logic          bypassTake;
   logic          bypassConsume;

   // Handshake decode. Redirect overrides everything, a full queue may still
   // accept a word when the head is leaving in the same cycle. With bypass
   // enabled, an empty queue forwards the memory word directly; if decode
   // takes it, it never enters storage but the fetch PC still advances.
   always_comb begin
      queueValid    = (count_q != '0);
      pop           = queueValid & ~stall & ~redirect;
`ifdef IFQ_BYPASS_EN
      bypassTake    = ~queueValid & imem_valid & ~redirect;
      bypassConsume = bypassTake & ~stall;
`else
      bypassTake    = 1'b0;
      bypassConsume = 1'b0;
`endif
      push          = imem_valid & ~redirect & ~bypassConsume
                      & ((count_q < FULL_COUNT) | pop);
      advance       = push | bypassConsume;
   end

   // Output selection: the head entry normally, or the in-flight memory word
   // when the bypass path is active.
   always_comb begin
      out_valid = queueValid | bypassTake;
      out_instr = instrMem[rdPtr_q];
      out_pc    = pcMem[rdPtr_q];
      if (bypassTake) begin
         out_instr = imem_data;
         out_pc    = fetchPc_q;
      end
      out_pc4   = out_pc + 32'd4;
      imem_addr = fetchPc_q;
      count     = count_q;
   end

   // Next-state for pointers, occupancy and fetch PC. A redirect clears the
   // queue and discards whatever memory returned this cycle.
   always_comb begin
      fetchPc_d = fetchPc_q;
      rdPtr_d   = rdPtr_q;
      wrPtr_d   = wrPtr_q;
      count_d   = count_q;
      if (redirect) begin
         fetchPc_d = {redirect_pc[31:2], 2'b00};
         rdPtr_d   = '0;
         wrPtr_d   = '0;
         count_d   = '0;
      end else begin
         if (advance) fetchPc_d = fetchPc_q + 32'd4;
         if (push)    wrPtr_d   = wrPtr_q + PW'(1);
         if (pop)     rdPtr_d   = rdPtr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; reset wins over redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetchPc_q <= RESET_PC;
         rdPtr_q   <= '0;
         wrPtr_q   <= '0;
         count_q   <= '0;
      end else begin
         fetchPc_q <= fetchPc_d;
         rdPtr_q   <= rdPtr_d;
         wrPtr_q   <= wrPtr_d;
         count_q   <= count_d;
      end
   end

   // Entry storage needs no reset: contents are only observed while counted
   // as occupied.
   always_ff @(posedge clk) begin
      if (push) begin
         pcMem[wrPtr_q]    <= fetchPc_q;
         instrMem[wrPtr_q] <= imem_data;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// ----------------------------------------------------------------------------
// tb_ifetch_queue
// Directed bench for ifetch_queue (DEPTH = 4, RESET_PC = 0, bypass disabled).
// The instruction memory is modelled as a pure function of the address, so
// the expected instruction for any PC is derived from that PC alone.
// ----------------------------------------------------------------------------
module tb_ifetch_queue;

   logic        clk;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        imem_valid;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc4;
   logic [2:0]  count;

   int assertCount = 0;
   int failCount   = 0;

   ifetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .imem_valid  (imem_valid),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_pc4     (out_pc4),
      .count       (count)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction memory model: each word is a fixed scramble of its address.
   function automatic logic [31:0] instrFor(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   assign imem_data = instrFor(imem_addr);

   // Advance one cycle; inputs and checks happen 1 unit after the edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Full head check: valid, pc, pc+4 and instruction.
   task automatic checkHead(input string tag, input logic [31:0] pc);
      checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      checkOutput({tag, "_pc"},    out_pc,    pc);
      checkOutput({tag, "_pc4"},   out_pc4,   pc + 32'd4);
      checkOutput({tag, "_instr"}, out_instr, instrFor(pc));
   endtask

   initial begin
      reset       = 1'b1;
      imem_valid  = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      applyStimulus();
      applyStimulus();

      // Reset state
      checkOutput("rst_count", {29'b0, count}, 32'd0);
      checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_addr",  imem_addr, 32'h0);

      // Streaming: one in, one out each cycle, occupancy stays at 1
      reset      = 1'b0;
      imem_valid = 1'b1;
      applyStimulus();
      for (int i = 1; i <= 5; i++) begin
         checkHead("stream", 32'(4 * (i - 1)));
         checkOutput("stream_count", {29'b0, count}, 32'd1);
         checkOutput("stream_addr",  imem_addr, 32'(4 * i));
         applyStimulus();
      end

      // Fill under stall from a fresh reset
      reset      = 1'b1;
      imem_valid = 1'b0;
      applyStimulus();
      reset      = 1'b0;
      stall      = 1'b1;
      imem_valid = 1'b1;
      for (int i = 0; i <= 4; i++) begin
         checkOutput("fill_count", {29'b0, count}, 32'(i));
         checkOutput("fill_addr",  imem_addr, 32'(4 * i));
         applyStimulus();
      end
      checkOutput("full_count", {29'b0, count}, 32'd4);
      checkOutput("full_addr",  imem_addr, 32'h10);
      checkHead("full_head", 32'h0);

      // Drain in order without new fetches
      stall      = 1'b0;
      imem_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         checkHead("drain", 32'(4 * j));
         checkOutput("drain_count", {29'b0, count}, 32'(4 - j));
         applyStimulus();
      end
      checkOutput("empty_count", {29'b0, count}, 32'd0);
      checkOutput("empty_valid", {31'b0, out_valid}, 32'd0);

      // Stall on an empty queue has no effect on occupancy
      stall = 1'b1;
      applyStimulus();
      checkOutput("empty_stall_count", {29'b0, count}, 32'd0);
      checkOutput("empty_stall_addr",  imem_addr, 32'h10);

      // Refill to full, then push and pop together
      imem_valid = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus();
      checkOutput("refill_count", {29'b0, count}, 32'd4);
      stall = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checkOutput("fullpp_count", {29'b0, count}, 32'd4);
         checkHead("fullpp", 32'h10 + 32'(4 * k));
         checkOutput("fullpp_addr", imem_addr, 32'h20 + 32'(4 * k));
         applyStimulus();
      end

      // Drop to three entries, then redirect while stalled
      imem_valid = 1'b0;
      applyStimulus();
      checkOutput("pre_redir_count", {29'b0, count}, 32'd3);
      checkHead("pre_redir", 32'h24);
      stall       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      imem_valid  = 1'b1;
      applyStimulus();
      redirect = 1'b0;
      stall    = 1'b0;
      checkOutput("redir_count", {29'b0, count}, 32'd0);
      checkOutput("redir_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("redir_addr",  imem_addr, 32'h100);
      applyStimulus();
      checkHead("redir_first", 32'h100);

      // Fetch PC wrap-around
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      applyStimulus();
      redirect = 1'b0;
      checkOutput("wrap_addr",  imem_addr, 32'hFFFF_FFF8);
      checkOutput("wrap_valid", {31'b0, out_valid}, 32'd0);
      applyStimulus();
      checkHead("wrap0", 32'hFFFF_FFF8);
      applyStimulus();
      checkHead("wrap1", 32'hFFFF_FFFC);
      checkOutput("wrap1_pc4", out_pc4, 32'h0000_0000);
      applyStimulus();
      checkHead("wrap2", 32'h0000_0000);

      // Reset colliding with redirect while two entries are held
      stall = 1'b1;
      applyStimulus();
      checkOutput("pre_rst_count", {29'b0, count}, 32'd2);
      reset       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      applyStimulus();
      reset      = 1'b0;
      redirect   = 1'b0;
      imem_valid = 1'b0;
      stall      = 1'b0;
      checkOutput("rst_redir_addr",  imem_addr, 32'h0);
      checkOutput("rst_redir_count", {29'b0, count}, 32'd0);
      checkOutput("rst_redir_valid", {31'b0, out_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
